// File: rtl/updown_pkg.sv
// Shared types and constants for the up/down counter.
// Build option UPDOWN_SATURATE_EN (used in updown_next) switches wrap to saturation.
package updown_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // All-ones bound for a counter of the given width (widths up to 32 bits).
  function automatic logic [31:0] all_ones(input int unsigned width);
    if (width >= 32) begin
      all_ones = 32'hFFFF_FFFF;
    end else begin
      all_ones = (32'd1 << width) - 32'd1;
    end
  endfunction

endpackage

// File: rtl/updown_next.sv
// Combinational next-state for updown_counter: load/step selection and terminal count.
// `ifdef UPDOWN_SATURATE_EN holds at the bounds instead of wrapping.
module updown_next
  import updown_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] next_count,
  output logic             next_tc
);

  localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(all_ones(WIDTH));
  localparam logic [WIDTH-1:0] MIN_COUNT = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

  logic at_max_s;
  logic at_min_s;

  assign at_max_s = (count == MAX_COUNT);
  assign at_min_s = (count == MIN_COUNT);

  // Load beats counting; din is only routed through when load is set.
  always_comb begin
    next_count = count;
    next_tc    = 1'b0;
    if (load) begin
      next_count = din;
      next_tc    = 1'b0;
    end else begin
      case (dir_e'(up))
        DIR_UP: begin
          if (at_max_s) begin
`ifdef UPDOWN_SATURATE_EN
            next_count = MAX_COUNT;
`else
            next_count = MIN_COUNT;
`endif
            next_tc = 1'b1;
          end else begin
            next_count = count + ONE;
            next_tc    = 1'b0;
          end
        end
        DIR_DOWN: begin
          if (at_min_s) begin
`ifdef UPDOWN_SATURATE_EN
            next_count = MIN_COUNT;
`else
            next_count = MAX_COUNT;
`endif
            next_tc = 1'b1;
          end else begin
            next_count = count - ONE;
            next_tc    = 1'b0;
          end
        end
        default: begin
          next_count = count;
          next_tc    = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/updown_counter.sv
// Up/down counter with parallel load and registered terminal-count flag.
// Define UPDOWN_SATURATE_EN to saturate at the bounds instead of wrapping.
module updown_counter
  import updown_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             up,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] out,
  output logic             tc
);

  logic [WIDTH-1:0] next_count_s;
  logic             next_tc_s;

  updown_next #(
    .WIDTH(WIDTH)
  ) u_next (
    .count     (out),
    .up        (up),
    .load      (load),
    .din       (din),
    .next_count(next_count_s),
    .next_tc   (next_tc_s)
  );

  // Output registers; synchronous reset overrides load and count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out <= {WIDTH{1'b0}};
      tc  <= 1'b0;
    end else begin
      out <= next_count_s;
      tc  <= next_tc_s;
    end
  end

endmodule

// File: tb/tb_updown_counter.sv
// Scoreboard bench for updown_counter: integer reference model, directed plus random stimulus.
// Follows UPDOWN_SATURATE_EN when the build defines it.
module tb_updown_counter;

  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;

  typedef struct packed {
    logic [W-1:0] out;
    logic         tc;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         load;
  logic         up;
  logic [W-1:0] din;
  logic [W-1:0] out;
  logic         tc;

  exp_t sb[$];
  int   model_cnt;
  int   checks;
  int   failures;

  updown_counter #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .up   (up),
    .din  (din),
    .out  (out),
    .tc   (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference behaviour computed with plain integer arithmetic.
  task automatic drive(input logic r, input logic l, input logic u, input logic [W-1:0] d);
    exp_t e;
    int   nxt;
    @(negedge clk);
    rst_n = r;
    load  = l;
    up    = u;
    din   = d;
    if (!r) begin
      model_cnt = 0;
      e.tc      = 1'b0;
    end else if (l) begin
      model_cnt = int'(d);
      e.tc      = 1'b0;
    end else begin
      nxt = u ? model_cnt + 1 : model_cnt - 1;
      if (nxt > MAXV || nxt < 0) begin
        e.tc = 1'b1;
`ifdef UPDOWN_SATURATE_EN
        model_cnt = (nxt > MAXV) ? MAXV : 0;
`else
        model_cnt = (nxt + MAXV + 1) % (MAXV + 1);
`endif
      end else begin
        model_cnt = nxt;
        e.tc      = 1'b0;
      end
    end
    e.out = W'(model_cnt);
    sb.push_back(e);
  endtask

  // Monitor: compare each registered output against the oldest expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks = checks + 1;
      if (out !== e.out) begin
        failures = failures + 1;
        $display("FAIL out: got %0d expected %0d at %0t", out, e.out, $time);
      end
      checks = checks + 1;
      if (tc !== e.tc) begin
        failures = failures + 1;
        $display("FAIL tc: got %0b expected %0b (out=%0d) at %0t", tc, e.tc, out, $time);
      end
    end
  end

  initial begin
    logic [W-1:0] xv;
    logic [W-1:0] d;
    logic         r;
    logic         l;
    logic         u;
    int           sel;
    xv        = 'x;
    checks    = 0;
    failures  = 0;
    model_cnt = 0;
    rst_n     = 1'b0;
    load      = 1'b0;
    up        = 1'b0;
    din       = {W{1'b0}};

    drive(1'b0, 1'b0, 1'b0, 4'd0);
    // Load then count up.
    drive(1'b1, 1'b1, 1'b1, 4'd8);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b1, xv);
    // Load then count down.
    drive(1'b1, 1'b1, 1'b0, 4'd8);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, xv);
    // Upper and lower bounds.
    drive(1'b1, 1'b1, 1'b1, 4'd14);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1, xv);
    drive(1'b1, 1'b1, 1'b0, 4'd1);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, xv);
    // Reset beats load, load ignores up.
    drive(1'b0, 1'b1, 1'b1, 4'd9);
    drive(1'b1, 1'b1, 1'b1, 4'd3);
    // Reset mid-count.
    drive(1'b1, 1'b1, 1'b1, 4'd5);
    drive(1'b1, 1'b0, 1'b1, xv);
    drive(1'b0, 1'b0, 1'b1, xv);
    drive(1'b1, 1'b0, 1'b1, xv);

    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 19) != 0);
      l   = ($urandom_range(0, 5) == 0);
      u   = 1'(($urandom % 2));
      sel = $urandom_range(0, 4);
      case (sel)
        0:       d = {W{1'b0}};
        1:       d = {{(W-1){1'b0}}, 1'b1};
        2:       d = {W{1'b1}};
        3:       d = {{(W-1){1'b1}}, 1'b0};
        default: d = W'($urandom);
      endcase
      if (!l && ($urandom_range(0, 3) == 0)) d = xv;
      drive(r, l, u, d);
    end

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      checks   = checks + 1;
      failures = failures + 1;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
